// File: rtl/vdic_mult_pkg.sv
// Shared types and helpers for the parity-protected multiply responder.
// Parity is computed over a zero-extended vector, which leaves it unchanged.
package vdic_mult_pkg;

   typedef enum logic [1:0] {IDLE, MUL, ERR} state_t;

   localparam int DEFAULT_WIDTH = 16;
   localparam int PARITY_MAX_W  = 64;

   function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] v);
      return ^v;
   endfunction

endpackage

// File: rtl/seq_mult_core.sv
// Sequential magnitude shift-add multiplier: one partial product per clock,
// sign applied combinationally to the final accumulation on the done step.
module seq_mult_core
   import vdic_mult_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 run,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int CW = $clog2(WIDTH);

   logic [WIDTH:0]     a_ext, b_ext, mag_a, mag_b;
   logic [2*WIDTH-1:0] mcand_reg, acc_reg, addend, acc_next;
   logic [WIDTH:0]     mplier_reg;
   logic [CW-1:0]      cnt_reg;
   logic               neg_reg;

   // One extra bit so that the most negative operand has a representable magnitude
   assign a_ext = {a[WIDTH-1], a};
   assign b_ext = {b[WIDTH-1], b};
   assign mag_a = a[WIDTH-1] ? (~a_ext + 1'b1) : a_ext;
   assign mag_b = b[WIDTH-1] ? (~b_ext + 1'b1) : b_ext;

   assign addend   = mplier_reg[0] ? mcand_reg : '0;
   assign acc_next = acc_reg + addend;
   assign product  = neg_reg ? (~acc_next + 1'b1) : acc_next;
   assign done     = run && (cnt_reg == CW'(WIDTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_reg  <= '0;
         mplier_reg <= '0;
         acc_reg    <= '0;
         cnt_reg    <= '0;
         neg_reg    <= 1'b0;
      end else if (start) begin
         mcand_reg  <= {{(WIDTH-1){1'b0}}, mag_a};
         mplier_reg <= mag_b;
         acc_reg    <= '0;
         cnt_reg    <= '0;
         neg_reg    <= a[WIDTH-1] ^ b[WIDTH-1];
      end else if (run) begin
         acc_reg    <= acc_next;
         mcand_reg  <= mcand_reg << 1;
         mplier_reg <= mplier_reg >> 1;
         cnt_reg    <= cnt_reg + 1'b1;
      end
   end

endmodule

// File: rtl/par_mult_responder.sv
// Responder side of the parity-protected multiply handshake: captures operands
// on req, pulses ack, and later pulses result_rdy with a registered product.
module par_mult_responder
   import vdic_mult_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req,
   input  logic [WIDTH-1:0]     arg_a,
   input  logic [WIDTH-1:0]     arg_b,
   input  logic                 arg_a_parity,
   input  logic                 arg_b_parity,
   output logic                 ack,
   output logic [2*WIDTH-1:0]   result,
   output logic                 result_parity,
   output logic                 result_rdy,
   output logic                 arg_parity_error
);

   state_t             state_reg, state_next;
   logic               ack_reg, ack_next;
   logic               rdy_reg, rdy_next;
   logic [2*WIDTH-1:0] result_reg, result_next;
   logic               rpar_reg, rpar_next;
   logic               perr_reg, perr_next;
   logic               start, core_done, parity_ok;
   logic [2*WIDTH-1:0] core_product;

   assign parity_ok = (arg_a_parity == even_parity(PARITY_MAX_W'(arg_a))) &&
                      (arg_b_parity == even_parity(PARITY_MAX_W'(arg_b)));

   seq_mult_core #(.WIDTH(WIDTH)) u_core (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .run     (state_reg == MUL),
      .a       (arg_a),
      .b       (arg_b),
      .done    (core_done),
      .product (core_product)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         ack_reg    <= 1'b0;
         rdy_reg    <= 1'b0;
         result_reg <= '0;
         rpar_reg   <= 1'b0;
         perr_reg   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         ack_reg    <= ack_next;
         rdy_reg    <= rdy_next;
         result_reg <= result_next;
         rpar_reg   <= rpar_next;
         perr_reg   <= perr_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      ack_next    = 1'b0;
      rdy_next    = 1'b0;
      result_next = result_reg;
      rpar_next   = rpar_reg;
      perr_next   = perr_reg;
      start       = 1'b0;
      unique case (state_reg)
         IDLE: begin
            if (req) begin
               start      = 1'b1;
               ack_next   = 1'b1;
               perr_next  = 1'b0;
               state_next = parity_ok ? MUL : ERR;
            end
         end
         MUL: begin
            if (core_done) begin
               result_next = core_product;
               rpar_next   = even_parity(PARITY_MAX_W'(core_product));
               rdy_next    = 1'b1;
               state_next  = IDLE;
            end
         end
         ERR: begin
            result_next = '0;
            rpar_next   = 1'b0;
            perr_next   = 1'b1;
            rdy_next    = 1'b1;
            state_next  = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign ack              = ack_reg;
   assign result_rdy       = rdy_reg;
   assign result           = result_reg;
   assign result_parity    = rpar_reg;
   assign arg_parity_error = perr_reg;

endmodule

// File: tb/tb_par_mult_responder.sv
// Randomized self-checking bench for par_mult_responder against an arithmetic
// reference (signed integer product, reduction-xor parity, fixed latencies).
module tb_par_mult_responder;

   localparam int W = 16;

   logic            clk, rst_n, req;
   logic [W-1:0]    arg_a, arg_b;
   logic            arg_a_parity, arg_b_parity;
   logic            ack, result_parity, result_rdy, arg_parity_error;
   logic [2*W-1:0]  result;

   int checks = 0;
   int failures = 0;

   par_mult_responder #(.WIDTH(W)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .req              (req),
      .arg_a            (arg_a),
      .arg_b            (arg_b),
      .arg_a_parity     (arg_a_parity),
      .arg_b_parity     (arg_b_parity),
      .ack              (ack),
      .result           (result),
      .result_parity    (result_parity),
      .result_rdy       (result_rdy),
      .arg_parity_error (arg_parity_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [2*W-1:0] ref_product(input logic [W-1:0] a, input logic [W-1:0] b);
      int pa, pb;
      pa = int'($signed(a));
      pb = int'($signed(b));
      return 32'(pa * pb);
   endfunction

   // Drives one transaction starting at a negedge; returns observations at the negedge where result_rdy is seen.
   task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic pa, input logic pb,
                          output int lat, output logic [2*W-1:0] res, output logic rp, output logic pe,
                          output logic pe_at_ack, output int extra_acks, output bit timeout);
      int n;
      req = 1'b1; arg_a = a; arg_b = b; arg_a_parity = pa; arg_b_parity = pb;
      timeout = 1'b0; n = 0; lat = 0; extra_acks = 0; res = '0; rp = 1'b0; pe = 1'b0; pe_at_ack = 1'b0;
      do begin @(negedge clk); n++; end while (!ack && n < 50);
      req = 1'b0;
      if (!ack) begin timeout = 1'b1; return; end
      pe_at_ack = arg_parity_error;
      do begin
         @(negedge clk); lat++;
         if (ack) extra_acks++;
      end while (!result_rdy && lat < 50);
      if (!result_rdy) timeout = 1'b1;
      res = result; rp = result_parity; pe = arg_parity_error;
   endtask

   task automatic check_txn(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic pa, input logic pb);
      int lat, xa;
      logic [2*W-1:0] res, exp_res;
      logic rp, pe, pea, bad, exp_rp;
      bit to;
      int exp_lat;
      bad     = (pa != ^a) || (pb != ^b);
      exp_res = bad ? '0 : ref_product(a, b);
      exp_rp  = ^exp_res;
      exp_lat = bad ? 1 : W;
      run_txn(a, b, pa, pb, lat, res, rp, pe, pea, xa, to);
      checks++;
      if (to) begin
         failures++;
         $display("FAIL %s timeout a=%h b=%h", name, a, b);
         return;
      end
      if (lat !== exp_lat || res !== exp_res || rp !== exp_rp || pe !== bad || pea !== 1'b0 || xa !== 0) begin
         failures++;
         $display("FAIL %s a=%h b=%h got lat=%0d res=%h rpar=%b perr=%b perr@ack=%b xacks=%0d want lat=%0d res=%h rpar=%b perr=%b perr@ack=0 xacks=0",
                  name, a, b, lat, res, rp, pe, pea, xa, exp_lat, exp_res, exp_rp, bad);
      end else
         $display("txn %s a=%h b=%h res=%h rpar=%b perr=%b lat=%0d", name, a, b, res, rp, pe, lat);
   endtask

   task automatic test_reset();
      int viol;
      rst_n = 1'b0;
      req = 1'($urandom); arg_a = W'($urandom); arg_b = W'($urandom);
      arg_a_parity = 1'($urandom); arg_b_parity = 1'($urandom);
      repeat (3) @(negedge clk);
      checks++;
      if ({ack, result, result_parity, result_rdy, arg_parity_error} !== '0) begin
         failures++;
         $display("FAIL reset_outputs got ack=%b res=%h rpar=%b rdy=%b perr=%b want all 0",
                  ack, result, result_parity, result_rdy, arg_parity_error);
      end
      req = 1'b0;
      rst_n = 1'b1;
      viol = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (ack !== 1'b0 || result_rdy !== 1'b0) viol++;
      end
      checks++;
      if (viol != 0) begin
         failures++;
         $display("FAIL reset_idle_quiet got %0d cycles with ack/rdy high, want 0", viol);
      end else
         $display("txn reset_idle quiet for 20 cycles");
   endtask

   task automatic test_directed();
      check_txn("three_x_minus5", 16'd3, 16'hFFFB, ^16'd3, ^16'hFFFB);
      check_txn("min_x_min", 16'h8000, 16'h8000, 1'b1, 1'b1);
      check_txn("max_x_min", 16'h7FFF, 16'h8000, 1'b1, 1'b1);
      check_txn("zero_a", 16'h0000, 16'h8123, 1'b0, ^16'h8123);
      check_txn("neg_x_zero", 16'hFFFF, 16'h0000, 1'b0, 1'b0);
   endtask

   task automatic test_parity_error();
      logic [2*W-1:0] held;
      check_txn("perr_a", 16'd1, 16'd2, 1'b0, 1'b1);
      held = result;
      repeat (3) @(negedge clk);
      checks++;
      if (arg_parity_error !== 1'b1 || result !== held) begin
         failures++;
         $display("FAIL perr_hold got perr=%b res=%h want perr=1 res=%h", arg_parity_error, result, held);
      end
      check_txn("perr_b", 16'h1234, 16'h0007, ^16'h1234, 1'b0);
      check_txn("after_perr_valid", 16'd9, 16'd11, ^16'd9, ^16'd11);
   endtask

   task automatic test_reset_midflight();
      int n, stray;
      logic [2*W-1:0] e;
      req = 1'b1; arg_a = 16'd100; arg_b = 16'd7; arg_a_parity = ^16'd100; arg_b_parity = ^16'd7;
      n = 0;
      do begin @(negedge clk); n++; end while (!ack && n < 50);
      req = 1'b0;
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({ack, result, result_parity, result_rdy, arg_parity_error} !== '0 || n >= 50) begin
         failures++;
         $display("FAIL async_reset got ack=%b res=%h rpar=%b rdy=%b perr=%b acked=%b want all 0",
                  ack, result, result_parity, result_rdy, arg_parity_error, n < 50);
      end
      @(negedge clk);
      rst_n = 1'b1;
      stray = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (result_rdy !== 1'b0 || ack !== 1'b0) stray++;
      end
      checks++;
      if (stray != 0) begin
         failures++;
         $display("FAIL discarded_op got %0d stray ack/rdy cycles want 0", stray);
      end
      e = ref_product(16'd100, 16'd7);
      check_txn("after_reset_100x7", 16'd100, 16'd7, ^16'd100, ^16'd7);
      checks++;
      if (result !== 32'd700 || result !== e) begin
         failures++;
         $display("FAIL value_700 got %h want %h", result, 32'd700);
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] ca, cb;
      logic [2*W-1:0] exp_q[$];
      logic [2*W-1:0] e;
      int cyc, last_ack, acks, rdys;
      ca = W'($urandom); cb = W'($urandom);
      req = 1'b1; arg_a = ca; arg_b = cb; arg_a_parity = ^ca; arg_b_parity = ^cb;
      cyc = 0; last_ack = -1; acks = 0; rdys = 0;
      while (rdys < 6 && cyc < 400) begin
         @(negedge clk); cyc++;
         if (ack) begin
            if (last_ack >= 0) begin
               checks++;
               if (cyc - last_ack != W + 1) begin
                  failures++;
                  $display("FAIL b2b_spacing got %0d want %0d", cyc - last_ack, W + 1);
               end
            end
            last_ack = cyc;
            exp_q.push_back(ref_product(ca, cb));
            acks++;
            ca = W'($urandom); cb = W'($urandom);
            arg_a = ca; arg_b = cb; arg_a_parity = ^ca; arg_b_parity = ^cb;
            if (acks >= 6) req = 1'b0;
         end
         if (result_rdy) begin
            rdys++;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            checks++;
            if (result !== e || result_parity !== ^e || arg_parity_error !== 1'b0) begin
               failures++;
               $display("FAIL b2b_result #%0d got res=%h rpar=%b perr=%b want res=%h rpar=%b perr=0",
                        rdys, result, result_parity, arg_parity_error, e, ^e);
            end else
               $display("txn b2b #%0d res=%h rpar=%b", rdys, result, result_parity);
         end
      end
      req = 1'b0;
      checks++;
      if (rdys < 6) begin
         failures++;
         $display("FAIL b2b_timeout got %0d results want 6", rdys);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_random();
      logic [W-1:0] a, b;
      logic pa, pb;
      for (int i = 0; i < 24; i++) begin
         a = W'($urandom);
         b = W'($urandom);
         if ((i % 6) == 1) a = 16'h8000;
         if ((i % 6) == 2) b = '0;
         pa = ^a ^ ($urandom_range(0, 7) == 0);
         pb = ^b ^ ($urandom_range(0, 7) == 0);
         check_txn("random", a, b, pa, pb);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
   endtask

   initial begin
      rst_n = 1'b0; req = 1'b0;
      arg_a = '0; arg_b = '0; arg_a_parity = 1'b0; arg_b_parity = 1'b0;
      test_reset();
      test_directed();
      test_parity_error();
      test_reset_midflight();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
